// File: rtl/ll1_hdown2_if.sv
// ll1_hdown2_if: SEND/ACK/RDY/COUNT token handshake bundle for the input and output sides of ll1_hdown2.
interface ll1_hdown2_if;
  logic [15:0] In1_DATA;
  logic        In1_SEND;
  logic [15:0] In1_COUNT;
  logic        In1_ACK;
  logic [15:0] Out1_DATA;
  logic        Out1_SEND;
  logic [15:0] Out1_COUNT;
  logic        Out1_RDY;
  logic        Out1_ACK;
  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );
  modport master (
    output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );
endinterface

// File: rtl/ll1_hdown2.sv
// ll1_hdown2: horizontal 1-2-1 low-pass with decimation by 2 on a 16-bit pixel token stream.
module ll1_hdown2 #(
  parameter int WIDTH = 8,
  parameter int COLW  = 16
) (
  input logic CLK,
  input logic RESET,
  ll1_hdown2_if.slave io
);
  typedef enum logic {ACCEPT, HOLD} state_t;
  state_t          state;
  logic [COLW-1:0] col;
  logic [15:0]     prev, ctr, out_reg;
  logic [17:0]     sum;
  assign sum = {2'b0, prev} + {1'b0, ctr, 1'b0} + {2'b0, io.In1_DATA} + 18'd2;
  assign io.In1_ACK    = io.In1_SEND & (state == ACCEPT) & ~RESET;
  assign io.Out1_SEND  = (state == HOLD) & io.Out1_RDY & ~RESET;
  assign io.Out1_DATA  = out_reg;
  assign io.Out1_COUNT = 16'h1;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state   <= ACCEPT;
      col     <= '0;
      prev    <= '0;
      ctr     <= '0;
      out_reg <= '0;
    end else if (state == HOLD) begin
      if (io.Out1_RDY) state <= ACCEPT;
    end else if (io.In1_SEND) begin
      if (!col[0]) begin
        ctr <= io.In1_DATA;
        // column 0 replicates itself as its left neighbour
        if (col == '0) prev <= io.In1_DATA;
        col <= col + COLW'(1);
      end else begin
        out_reg <= sum[17:2];
        prev    <= io.In1_DATA;
        state   <= HOLD;
        col     <= (col == COLW'(WIDTH - 1)) ? '0 : col + COLW'(1);
      end
    end
endmodule

// File: tb/tb_ll1_hdown2.sv
// tb_ll1_hdown2: randomized and directed stimulus checked every cycle against a row-level reference model.
module tb_ll1_hdown2;
  localparam int WIDTH = 8;
  logic CLK = 0, RESET = 1;
  ll1_hdown2_if io ();
  ll1_hdown2 #(.WIDTH(WIDTH), .COLW(16)) dut (.CLK(CLK), .RESET(RESET), .io(io.slave));
  always #5 CLK = ~CLK;
  int pass_cnt = 0, total_cnt = 0;
  logic [15:0] src[$];
  logic [15:0] out_log[$];
  logic [15:0] rowp[WIDTH];
  int mcol = 0, acc_cnt = 0;
  bit hold = 0;
  logic [15:0] hold_val = 0;
  int send_pct = 100, rdy_pct = 100;
  bit toggle = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [15:0] filt(int c, logic [15:0] d);
    int k = c / 2;
    int a = (k == 0) ? int'(rowp[0]) : int'(rowp[2*k-1]);
    return 16'((a + 2 * int'(rowp[2*k]) + int'(d) + 2) / 4);
  endfunction
  initial begin
    bit was_rst = 1, ph = 0;
    io.In1_SEND = 0; io.In1_DATA = 0; io.In1_COUNT = 0; io.Out1_RDY = 0; io.Out1_ACK = 0;
    forever begin
      @(posedge CLK); #1;
      ph = ~ph;
      io.In1_SEND  = (src.size() > 0) && !RESET && !was_rst &&
                     (toggle ? ph : ($urandom_range(99) < send_pct));
      io.In1_DATA  = (src.size() > 0) ? src[0] : 16'($urandom);
      io.In1_COUNT = 16'($urandom);
      io.Out1_ACK  = 1'($urandom);
      io.Out1_RDY  = $urandom_range(99) < rdy_pct;
      was_rst = RESET;
    end
  end
  always @(negedge CLK) begin
    if (RESET) begin
      chk("rst_ack", io.In1_ACK, 0);
      chk("rst_send", io.Out1_SEND, 0);
      chk("rst_data", io.Out1_DATA, 0);
      chk("rst_count", io.Out1_COUNT, 1);
      mcol = 0; hold = 0;
    end else begin
      chk("count", io.Out1_COUNT, 1);
      chk("in_ack", io.In1_ACK, io.In1_SEND && !hold);
      chk("out_send", io.Out1_SEND, hold && io.Out1_RDY);
      if (hold) chk("out_data", io.Out1_DATA, hold_val);
      if (hold && io.Out1_RDY) begin
        out_log.push_back(hold_val);
        hold = 0;
      end else if (!hold && io.In1_SEND) begin
        if (src.size() > 0) begin
          chk("src_data", io.In1_DATA, src[0]);
          void'(src.pop_front());
        end
        acc_cnt++;
        rowp[mcol] = io.In1_DATA;
        if (mcol % 2 == 1) begin
          hold_val = filt(mcol, io.In1_DATA);
          hold = 1;
        end
        mcol = (mcol == WIDTH - 1) ? 0 : mcol + 1;
      end
    end
  end
  task automatic drain(string name);
    int n = 0;
    while ((src.size() > 0 || hold) && n < 2000) begin
      @(negedge CLK); n++;
    end
    @(negedge CLK);
    if (n >= 2000) begin
      total_cnt++;
      $display("FAIL %s: drain timeout, %0d pixels left", name, src.size());
    end
  endtask
  task automatic chk_log(string name, logic [15:0] e[$]);
    chk({name, "_n"}, out_log.size(), e.size());
    foreach (e[i]) if (i < out_log.size()) chk(name, out_log[i], e[i]);
    out_log.delete();
  endtask
  task automatic push_row(logic [15:0] r[$]);
    foreach (r[i]) src.push_back(r[i]);
  endtask
  initial begin
    logic [15:0] row1[$] = '{10, 20, 30, 40, 50, 60, 70, 80};
    repeat (3) @(posedge CLK);
    #2 RESET = 0;
    // basic row and seamless second row
    push_row(row1);
    acc_cnt = 0;
    drain("basic");
    chk("basic_acks", acc_cnt, 8);
    chk_log("basic", '{13, 30, 50, 70});
    push_row('{100, 0, 0, 0, 0, 0, 0, 0});
    drain("edge");
    chk_log("edge", '{75, 0, 0, 0});
    push_row('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    drain("full");
    chk_log("full", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    // backpressure: output stalls the input after the first pair
    rdy_pct = 0; acc_cnt = 0;
    push_row(row1);
    repeat (22) @(negedge CLK);
    chk("bp_acks", acc_cnt, 2);
    chk("bp_data", io.Out1_DATA, 13);
    chk("bp_ack", io.In1_ACK, 0);
    chk("bp_send", io.Out1_SEND, 0);
    rdy_pct = 100;
    drain("bp");
    chk_log("bp", '{13, 30, 50, 70});
    // reset mid-row discards the partial row
    push_row('{10, 20, 30});
    drain("rst_pre");
    chk_log("rst_pre", '{13});
    @(posedge CLK); #2 RESET = 1;
    @(posedge CLK); #2 RESET = 0;
    push_row('{40, 80, 0, 0, 0, 0, 0, 0});
    drain("rst_post");
    chk_log("rst_post", '{50, 20, 0, 0});
    // sparse input
    toggle = 1;
    push_row(row1);
    drain("sparse");
    chk_log("sparse", '{13, 30, 50, 70});
    toggle = 0;
    // random traffic
    send_pct = 70; rdy_pct = 60;
    for (int r = 0; r < 20; r++)
      for (int i = 0; i < WIDTH; i++) src.push_back(16'($urandom));
    drain("rand");
    chk("rand_n", out_log.size(), 20 * WIDTH / 2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
